// File: rtl/accel_poll_sequencer_if.sv
// Byte-level handshake between the acquisition sequencer and i2c_master.
// The master modport is the sequencer side; the slave modport is i2c_master.
interface accel_poll_sequencer_if;
  logic       i2c_valid;
  logic [6:0] i2c_addr;
  logic       i2c_rnw;
  logic [7:0] i2c_data_wr;
  logic       i2c_busy;
  logic [7:0] i2c_data_rd;
  logic       i2c_ack_error;

  modport master (
    output i2c_valid, i2c_addr, i2c_rnw, i2c_data_wr,
    input  i2c_busy, i2c_data_rd, i2c_ack_error
  );

  modport slave (
    input  i2c_valid, i2c_addr, i2c_rnw, i2c_data_wr,
    output i2c_busy, i2c_data_rd, i2c_ack_error
  );
endinterface

// File: rtl/accel_poll_sequencer.sv
// CPU-free accelerometer poller: configures the device once, then reads
// X/Y/Z (6 bytes) on every poll tick and presents them as signed samples.
module accel_poll_sequencer #(
  parameter int         GC_SYSTEM_CLK = 50000000,
  parameter int         POLL_HZ       = 100,
  parameter logic [6:0] DEV_ADDR      = 7'h53,
  parameter logic [7:0] CFG_REG       = 8'h2D,
  parameter logic [7:0] CFG_VAL       = 8'h08,
  parameter logic [7:0] DATA_REG      = 8'h32,
  parameter int         MAX_RETRY     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   error_clr,
  accel_poll_sequencer_if.master i2c,
  output logic signed [15:0]     sample_x,
  output logic signed [15:0]     sample_y,
  output logic signed [15:0]     sample_z,
  output logic                   sample_valid,
  output logic                   cfg_done,
  output logic                   error,
  output logic [7:0]             overrun_cnt
);

  localparam int TICK_PERIOD = GC_SYSTEM_CLK / POLL_HZ;
  localparam int TICK_W      = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam int RETRY_W     = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    sIDLE, sCFG_PTR, sCFG_VAL, sCFG_STOP, sWAIT_TICK,
    sRD_PTR, sRD_BYTE, sABORT, sERROR
  } state_t;

  state_t               state_q, state_d;
  logic                 busy_q;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [2:0]           byte_idx_q, byte_idx_d;
  logic [2:0]           rise_idx_q, rise_idx_d;
  logic                 ptr_pend_q, ptr_pend_d;
  logic                 vld_off_q, vld_off_d;
  logic                 abort_cfg_q, abort_cfg_d;
  logic [7:0]           shadow_q [5];
  logic [7:0]           shadow_d [5];
  logic signed [15:0]   sample_x_q, sample_x_d;
  logic signed [15:0]   sample_y_q, sample_y_d;
  logic signed [15:0]   sample_z_q, sample_z_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 cfg_done_q, cfg_done_d;
  logic                 error_q, error_d;
  logic [7:0]           overrun_q, overrun_d;

  logic                 rise, fall, ack_abort, tick_wrap;
  logic                 valid_c, rnw_c;
  logic [7:0]           data_wr_c;

  assign rise      = i2c.i2c_busy & ~busy_q;
  assign fall      = ~i2c.i2c_busy & busy_q;
  assign ack_abort = fall & i2c.i2c_ack_error;
  assign tick_wrap = cfg_done_q && (tick_q == TICK_W'(TICK_PERIOD - 1));

  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    retry_d        = retry_q;
    byte_idx_d     = byte_idx_q;
    rise_idx_d     = rise_idx_q;
    ptr_pend_d     = ptr_pend_q;
    vld_off_d      = vld_off_q;
    abort_cfg_d    = abort_cfg_q;
    shadow_d       = shadow_q;
    sample_x_d     = sample_x_q;
    sample_y_d     = sample_y_q;
    sample_z_d     = sample_z_q;
    sample_valid_d = 1'b0;
    cfg_done_d     = cfg_done_q;
    error_d        = error_q;
    overrun_d      = overrun_q;
    valid_c        = 1'b0;
    rnw_c          = 1'b0;
    data_wr_c      = 8'h00;

    // Poll timer free-runs once configured; reads never stretch its period.
    if (!cfg_done_q || tick_wrap) tick_d = '0;
    else                          tick_d = tick_q + 1'b1;

    if (tick_wrap && (state_q == sRD_PTR || state_q == sRD_BYTE) && overrun_q != 8'hFF)
      overrun_d = overrun_q + 8'd1;

    case (state_q)
      sIDLE: if (enable) state_d = sCFG_PTR;

      sCFG_PTR: begin
        valid_c   = 1'b1;
        data_wr_c = CFG_REG;
        if (rise) state_d = sCFG_VAL;
      end

      sCFG_VAL: begin
        valid_c   = 1'b1;
        data_wr_c = CFG_VAL;
        if (ack_abort) begin
          valid_c     = 1'b0;
          abort_cfg_d = 1'b1;
          state_d     = sABORT;
        end else if (rise) begin
          state_d = sCFG_STOP;
        end
      end

      sCFG_STOP: begin
        if (ack_abort) begin
          abort_cfg_d = 1'b1;
          state_d     = sABORT;
        end else if (fall) begin
          retry_d    = '0;
          cfg_done_d = enable;
          state_d    = enable ? sWAIT_TICK : sIDLE;
        end
      end

      sWAIT_TICK: begin
        if (!enable) begin
          cfg_done_d = 1'b0;
          state_d    = sIDLE;
        end else if (tick_wrap) begin
          state_d = sRD_PTR;
        end
      end

      sRD_PTR: begin
        valid_c   = 1'b1;
        data_wr_c = DATA_REG;
        if (rise) begin
          byte_idx_d = '0;
          rise_idx_d = '0;
          ptr_pend_d = 1'b1;
          vld_off_d  = 1'b0;
          state_d    = sRD_BYTE;
        end
      end

      // The first fall seen here belongs to the pointer byte, not to data.
      sRD_BYTE: begin
        valid_c = ~vld_off_q;
        rnw_c   = 1'b1;
        if (ack_abort) begin
          valid_c     = 1'b0;
          abort_cfg_d = 1'b0;
          state_d     = sABORT;
        end else if (rise) begin
          rise_idx_d = rise_idx_q + 3'd1;
          if (rise_idx_q == 3'd5) vld_off_d = 1'b1;
        end else if (fall) begin
          if (ptr_pend_q) begin
            ptr_pend_d = 1'b0;
          end else if (byte_idx_q == 3'd5) begin
            sample_x_d     = $signed({shadow_q[1], shadow_q[0]});
            sample_y_d     = $signed({shadow_q[3], shadow_q[2]});
            sample_z_d     = $signed({i2c.i2c_data_rd, shadow_q[4]});
            sample_valid_d = 1'b1;
            retry_d        = '0;
            cfg_done_d     = enable;
            state_d        = enable ? sWAIT_TICK : sIDLE;
          end else begin
            shadow_d[byte_idx_q] = i2c.i2c_data_rd;
            byte_idx_d           = byte_idx_q + 3'd1;
          end
        end
      end

      sABORT: begin
        if (!i2c.i2c_busy) begin
          retry_d = retry_q + 1'b1;
          if (int'(retry_q) + 1 >= MAX_RETRY) begin
            error_d = 1'b1;
            state_d = sERROR;
          end else begin
            state_d = abort_cfg_q ? sCFG_PTR : sWAIT_TICK;
          end
        end
      end

      sERROR: begin
        if (error_clr) begin
          error_d    = 1'b0;
          retry_d    = '0;
          cfg_done_d = 1'b0;
          state_d    = sIDLE;
        end
      end

      default: state_d = sIDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= sIDLE;
      busy_q         <= 1'b0;
      tick_q         <= '0;
      retry_q        <= '0;
      byte_idx_q     <= '0;
      rise_idx_q     <= '0;
      ptr_pend_q     <= 1'b0;
      vld_off_q      <= 1'b0;
      abort_cfg_q    <= 1'b0;
      shadow_q       <= '{default: 8'h00};
      sample_x_q     <= '0;
      sample_y_q     <= '0;
      sample_z_q     <= '0;
      sample_valid_q <= 1'b0;
      cfg_done_q     <= 1'b0;
      error_q        <= 1'b0;
      overrun_q      <= 8'h00;
    end else begin
      state_q        <= state_d;
      busy_q         <= i2c.i2c_busy;
      tick_q         <= tick_d;
      retry_q        <= retry_d;
      byte_idx_q     <= byte_idx_d;
      rise_idx_q     <= rise_idx_d;
      ptr_pend_q     <= ptr_pend_d;
      vld_off_q      <= vld_off_d;
      abort_cfg_q    <= abort_cfg_d;
      shadow_q       <= shadow_d;
      sample_x_q     <= sample_x_d;
      sample_y_q     <= sample_y_d;
      sample_z_q     <= sample_z_d;
      sample_valid_q <= sample_valid_d;
      cfg_done_q     <= cfg_done_d;
      error_q        <= error_d;
      overrun_q      <= overrun_d;
    end
  end

  assign i2c.i2c_valid   = valid_c;
  assign i2c.i2c_addr    = valid_c ? DEV_ADDR : 7'h00;
  assign i2c.i2c_rnw     = rnw_c;
  assign i2c.i2c_data_wr = data_wr_c;

  assign sample_x     = sample_x_q;
  assign sample_y     = sample_y_q;
  assign sample_z     = sample_z_q;
  assign sample_valid = sample_valid_q;
  assign cfg_done     = cfg_done_q;
  assign error        = error_q;
  assign overrun_cnt  = overrun_q;

endmodule

// File: doc/accel_poll_sequencer.md
Name: accel_poll_sequencer

Overview:
- Autonomous controller that drives the existing i2c_master byte-level port directly, with no CPU in the loop.
- After enable, writes one configuration byte to the accelerometer. It then reads 6 data bytes (X0,X1,Y0,Y1,Z0,Z1) at a fixed poll rate and presents them as three signed 16-bit samples with a valid strobe.
- Sits beside i2c_avalon_mm_if as a low-latency, CPU-free acquisition path. Only one of the two may own i2c_master (selected at top level).

Parameters:
- GC_SYSTEM_CLK, 50000000, system clock frequency in Hz.
- POLL_HZ, 100, sample rate in Hz; tick period = GC_SYSTEM_CLK/POLL_HZ cycles.
- DEV_ADDR, 7'h53, 7-bit I2C device address.
- CFG_REG, 8'h2D, configuration register pointer.
- CFG_VAL, 8'h08, value written to CFG_REG (measure mode).
- DATA_REG, 8'h32, first data register pointer (auto-increment device).
- MAX_RETRY, 3, consecutive failed transactions before entering sERROR.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run sequencer.
- error_clr  in  1  single-cycle pulse; leaves sERROR.
- i2c_valid  out  1  to i2c_master valid.
- i2c_addr  out  7  to i2c_master addr.
- i2c_rnw  out  1  to i2c_master rnw.
- i2c_data_wr  out  8  to i2c_master data_wr.
- i2c_busy  in  1  from i2c_master.
- i2c_data_rd  in  8  from i2c_master.
- i2c_ack_error  in  1  from i2c_master.
- sample_x, sample_y, sample_z  out  16 each  last complete sample, {byte1,byte0}.
- sample_valid  out  1  one-cycle pulse when all three samples update.
- cfg_done  out  1  configuration write succeeded.
- error  out  1  sticky; set on entering sERROR.
- overrun_cnt  out  8  ticks dropped because a read was still in progress; saturates at 255.

Behaviour:
- Reset: all outputs 0, state sIDLE, tick counter 0, retry count 0. Reset is asynchronous and aborts any transaction immediately; i2c_master is reset by the same net.
- Busy edges: busy_q is a registered copy of i2c_busy. rise = i2c_busy & ~busy_q (byte accepted). fall = ~i2c_busy & busy_q (byte done; data_rd and ack_error are valid in that cycle).
- Transaction rule: i2c_addr = DEV_ADDR whenever i2c_valid = 1. Hold i2c_valid high to continue. Changing rnw while valid is high produces a repeated start. Drop i2c_valid on the rise of the last byte to get a stop. A transaction is finished on the next fall.
- sIDLE: outputs to i2c_master deasserted. If enable = 1, go to sCFG_PTR.
- sCFG_PTR: valid = 1, rnw = 0, data_wr = CFG_REG. On rise, go to sCFG_VAL.
- sCFG_VAL: data_wr = CFG_VAL. On rise, drop valid and go to sCFG_STOP.
- sCFG_STOP: on fall, set cfg_done, clear retry count, go to sWAIT_TICK.
- sWAIT_TICK: tick counter counts 0..GC_SYSTEM_CLK/POLL_HZ-1 and wraps; it runs only while cfg_done = 1. On wrap, go to sRD_PTR and set byte index = 0. If enable = 0, go to sIDLE and clear cfg_done.
- sRD_PTR: valid = 1, rnw = 0, data_wr = DATA_REG. On rise, go to sRD_BYTE with rnw = 1 (repeated start).
- sRD_BYTE: on each fall, store data_rd into shadow[byte index] and increment the index. On the rise for index 5, drop valid. After the fall for index 5, copy the shadow registers to sample_x/y/z and pulse sample_valid in the following cycle. Clear retry count and return to sWAIT_TICK.
- Overrun: a tick wrap while in sRD_PTR or sRD_BYTE is dropped and increments overrun_cnt. The counter itself keeps running.
- Ack error: any fall with i2c_ack_error = 1 aborts the transaction.
  - Drop valid immediately, wait until i2c_busy = 0, then increment retry count.
  - Config phase: retry from sCFG_PTR.
  - Read phase: discard the shadow registers; sample outputs are unchanged and there is no sample_valid. Return to sWAIT_TICK.
  - When retry count reaches MAX_RETRY, go to sERROR.
- sERROR: error = 1, valid = 0. On error_clr, clear error, retry count and cfg_done, then go to sIDLE.
- Enable low mid-transaction: the current transaction completes normally (including sample update), then the block goes to sIDLE and clears cfg_done.
- Priority: reset > ack_error abort > normal sequencing. error_clr is ignored outside sERROR.

Test Plan:
- Bench setup for all scenarios: GC_SYSTEM_CLK=1000, POLL_HZ=100 (tick every 10 cycles), behavioural i2c_master model that takes 20 cycles per byte.
- Config: enable=1 -> bytes 2D, 08 written to addr 53 with rnw=0, stop issued, cfg_done=1; no read starts before the first tick.
- Read: model returns 34,12,78,56,BC,9A -> sample_x=1234, sample_y=5678, sample_z=9ABC, one sample_valid pulse. The repeated start follows pointer 32.
- Overrun: tick period is shorter than a 7-byte read -> overrun_cnt increments once per dropped tick, saturates at 255, and sampling continues.
- Ack error: model NACKs the 3rd read byte once -> valid dropped, samples unchanged, no sample_valid; the next tick yields a good sample and retry count returns to 0.
- Persistent NACK: 3 consecutive NACKs on config -> error=1, sERROR. error_clr -> reconfiguration succeeds and cfg_done=1.
- Reset mid-sRD_BYTE: assert reset -> all outputs 0 immediately. After release with enable=1, config restarts from sCFG_PTR.
